// File: rtl/led_pkg.sv
// Shared types and elaboration-time helpers for the LED blink driver.
// Holds the FSM state encoding and the width helper used for timer/counter sizing.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } led_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_blink_driver_cycle_timer.sv
// Loadable down-counter shared by the ON and OFF phases of the blink driver.
// The zero flag is registered alongside the count so it never adds a decode path.
module cycle_timer
    import led_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end

endmodule

// File: rtl/led_blink_driver.sv
// Plays BLINKS x (ON_CYCLES high, OFF_CYCLES low) on out for each accepted pulse on in.
// Optional feature macro: LED_BLINK_PENDING_EN queues pulses arriving while busy.
module led_blink_driver
    import led_pkg::*;
#(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int BLINKS     = 3,
    parameter int PEND_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic busy
);

    localparam int TW = clog2_min1((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
    localparam int BW = clog2_min1(BLINKS);

    localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD   = TW'(OFF_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINKS - 1);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || BLINKS < 1 || PEND_W < 1) begin : g_bad_params
        $error("led_blink_driver: ON_CYCLES, OFF_CYCLES, BLINKS and PEND_W must all be >= 1");
    end

    led_state_e    state;
    led_state_e    state_nxt;
    logic [BW-1:0] blinks;
    logic [BW-1:0] blinks_nxt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          seq_end;
    logic          restart;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign seq_end = (state == OFF) && tmr_zero && (blinks == '0);

`ifdef LED_BLINK_PENDING_EN
    logic [PEND_W-1:0] pending;
    logic              pend_inc;

    // A pulse on the end-of-sequence edge is counted first, so it can drive the restart.
    assign pend_inc = in && (state != IDLE) && (pending != '1);
    assign restart  = (pending != '0) || pend_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (seq_end && restart) begin
            pending <= pend_inc ? pending : pending - PEND_W'(1);
        end else if (pend_inc) begin
            pending <= pending + PEND_W'(1);
        end
    end
`else
    assign restart = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        blinks_nxt = blinks;
        tmr_load   = 1'b0;
        tmr_val    = ON_LOAD;
        case (state)
            IDLE: begin
                if (in) begin
                    state_nxt  = ON;
                    blinks_nxt = BLINK_LOAD;
                    tmr_load   = 1'b1;
                end
            end
            ON: begin
                if (tmr_zero) begin
                    state_nxt = OFF;
                    tmr_load  = 1'b1;
                    tmr_val   = OFF_LOAD;
                end
            end
            OFF: begin
                if (tmr_zero) begin
                    if (blinks != '0) begin
                        state_nxt  = ON;
                        blinks_nxt = blinks - BW'(1);
                        tmr_load   = 1'b1;
                    end else if (seq_end && restart) begin
                        state_nxt  = ON;
                        blinks_nxt = BLINK_LOAD;
                        tmr_load   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out and busy are registered from the next state, keeping in off any output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            blinks <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            blinks <= blinks_nxt;
            out    <= (state_nxt == ON);
            busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_led_blink_driver.sv
// Self-checking bench for led_blink_driver: directed scenarios plus random pulses,
// compared each cycle against a sequence-position reference model.
module tb_led_blink_driver;

    localparam int ON_C   = 3;
    localparam int OFF_C  = 2;
    localparam int BLK    = 2;
    localparam int PW     = 2;
    localparam int PERIOD = ON_C + OFF_C;
    localparam int LEN    = BLK * PERIOD;
    localparam int PMAX   = (1 << PW) - 1;

    logic clk;
    logic reset;
    logic trig;
    logic out;
    logic busy;

    int n_tests;
    int n_fail;
    int cyc;

    // Reference model: whether a sequence is playing, how far into it, and queued requests.
    bit m_active;
    int m_elapsed;
    int m_pend;

    led_blink_driver #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .BLINKS     (BLK),
        .PEND_W     (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in    (trig),
        .out   (out),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_pend    = 0;
    endtask

    task automatic model_edge(input logic v);
        if (!m_active) begin
            if (v) begin
                m_active  = 1'b1;
                m_elapsed = 0;
            end
        end else begin
`ifdef LED_BLINK_PENDING_EN
            if (v && m_pend < PMAX) m_pend++;
`endif
            m_elapsed++;
            if (m_elapsed == LEN) begin
                if (m_pend > 0) begin
                    m_pend--;
                    m_elapsed = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_out;
        logic exp_busy;
        exp_busy = m_active;
        exp_out  = m_active && ((m_elapsed % PERIOD) < ON_C);
        check({tag, ".out"}, out, exp_out);
        check({tag, ".busy"}, busy, exp_busy);
    endtask

    task automatic step(input logic v, input string tag);
        trig = v;
        @(posedge clk);
        cyc++;
        model_edge(v);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset between edges, held across an edge with in=1, then released.
    task automatic mid_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs({tag, ".async"});
        trig = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        check_outputs({tag, ".held"});
        #1;
        reset = 1'b0;
        trig  = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        trig    = 1'b0;
        model_clear();
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        step(1'b0, "idle");

        // Single pulse: full two-blink sequence, then idle.
        step(1'b1, "single");
        repeat (13) step(1'b0, "single");

        // Reset mid-sequence, then a fresh pulse after release.
        step(1'b1, "midrst");
        repeat (4) step(1'b0, "midrst");
        mid_reset("midrst");
        repeat (3) step(1'b0, "postrst");
        step(1'b1, "postrst");
        repeat (12) step(1'b0, "postrst");

        // in held high for three cycles.
        repeat (3) step(1'b1, "held");
        repeat (12) step(1'b0, "held");

        // Pulses at 0,2,4,6,8: overflow of the pending counter when enabled.
        for (int i = 0; i < 10; i++) step((i % 2) == 0, "burst");
        repeat (40) step(1'b0, "burst");

        // Pulse on the end-of-sequence edge, then another two cycles later.
        step(1'b1, "endedge");
        repeat (9) step(1'b0, "endedge");
        step(1'b1, "endedge");
        step(1'b0, "endedge");
        step(1'b1, "endedge");
        repeat (35) step(1'b0, "endedge");

        // Random pulses with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) mid_reset("rand");
            step($urandom_range(0, 4) == 0, "rand");
        end
        repeat (LEN * (PMAX + 2)) step(1'b0, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
